// File: rtl/ct_cp0_cluster_lpmd_ctrl_if.sv
// ct_cp0_cluster_lpmd_ctrl_if: core/L2 low-power handshake bundle; pad_cluster_dbg_req exists only with CLUSTER_LPMD_DBG_EN
interface ct_cp0_cluster_lpmd_ctrl_if #(
  parameter int CORE_NUM = 4
);
  logic [2*CORE_NUM-1:0] core_lpmd_b;
  logic [CORE_NUM-1:0]   core_wake_req;
  logic                  l2_no_op_ack;
`ifdef CLUSTER_LPMD_DBG_EN
  logic                  pad_cluster_dbg_req;
`endif
  logic                  cluster_no_op_req;
  logic                  cluster_clk_en;
  logic [1:0]            cluster_lpmd_b;
  logic [2:0]            cluster_state;

  modport master (
    input  core_lpmd_b, core_wake_req, l2_no_op_ack,
`ifdef CLUSTER_LPMD_DBG_EN
    input  pad_cluster_dbg_req,
`endif
    output cluster_no_op_req, cluster_clk_en, cluster_lpmd_b, cluster_state
  );

  modport slave (
    output core_lpmd_b, core_wake_req, l2_no_op_ack,
`ifdef CLUSTER_LPMD_DBG_EN
    output pad_cluster_dbg_req,
`endif
    input  cluster_no_op_req, cluster_clk_en, cluster_lpmd_b, cluster_state
  );
endinterface

// File: rtl/ct_cp0_cluster_lpmd_ctrl.sv
// ct_cp0_cluster_lpmd_ctrl: cluster low-power sequencer (drain L2, settle, gate clock, timed wake); CLUSTER_LPMD_DBG_EN adds external debug wake
module ct_cp0_cluster_lpmd_ctrl #(
  parameter int CORE_NUM  = 4,
  parameter int ENTRY_DLY = 4,
  parameter int EXIT_DLY  = 8,
  parameter int CNT_W     = 4
)(
  input logic cpuclk,
  input logic cpurst_b,
  ct_cp0_cluster_lpmd_ctrl_if.master lp
);
  typedef enum logic [2:0] {
    RUN    = 3'b000,
    DRAIN  = 3'b001,
    SETTLE = 3'b010,
    SLEEP  = 3'b011,
    WAKE   = 3'b100
  } state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             all_lpmd, wake, abort;
  logic             no_op_q, clk_en_q;
  logic [1:0]       lpmd_q;

  // every core reports a non-running lpmd code
  always_comb begin
    all_lpmd = 1'b1;
    for (int i = 0; i < CORE_NUM; i++)
      all_lpmd = all_lpmd & (lp.core_lpmd_b[2*i+:2] != 2'b11);
  end

`ifdef CLUSTER_LPMD_DBG_EN
  assign wake = (|lp.core_wake_req) | lp.pad_cluster_dbg_req;
`else
  assign wake = |lp.core_wake_req;
`endif
  assign abort = wake | ~all_lpmd;

  // next state and delay counter; counter is forced to zero whenever heading to RUN
  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    case (state)
      RUN:    nxt = (all_lpmd && !wake) ? DRAIN : RUN;
      DRAIN:  if (abort) nxt = RUN;
              else if (lp.l2_no_op_ack) begin
                nxt     = SETTLE;
                nxt_cnt = CNT_W'(ENTRY_DLY);
              end
      SETTLE: if (abort) nxt = RUN;
              else if (cnt == '0) nxt = SLEEP;
              else nxt_cnt = cnt - 1'b1;
      SLEEP:  if (abort) begin
                nxt     = WAKE;
                nxt_cnt = CNT_W'(EXIT_DLY);
              end
      WAKE:   if (cnt == '0) nxt = RUN;
              else nxt_cnt = cnt - 1'b1;
      default: nxt = RUN;
    endcase
    if (nxt == RUN) nxt_cnt = '0;
  end

  // state, counter and outputs registered together so outputs follow the registered state only
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= RUN;
      cnt      <= '0;
      no_op_q  <= 1'b0;
      clk_en_q <= 1'b1;
      lpmd_q   <= 2'b11;
    end else begin
      state    <= nxt;
      cnt      <= nxt_cnt;
      no_op_q  <= nxt != RUN;
      clk_en_q <= nxt != SLEEP;
      lpmd_q   <= (nxt == SLEEP) ? 2'b00 : 2'b11;
    end
  end

  assign lp.cluster_no_op_req = no_op_q;
  assign lp.cluster_clk_en    = clk_en_q;
  assign lp.cluster_lpmd_b    = lpmd_q;
  assign lp.cluster_state     = state;
endmodule
